serialisering: RTL and testbench
================================

# serialisering

Time-multiplexed counterpart to the three-lane parallel vector-multiply stage. It computes the same three element-wise vector products (A·B→G, C·D→H, E·F→I, four 8-bit elements each) through one shared 8×8 multiplier over twelve cycles. Operands are captured with a start/done handshake. It replaces the parallel stage where area matters more than latency, and exposes the same operand and result naming to the surrounding datapath.

## Interface
- `W`, default 8: element width in bits for operands and results.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a computation. Sampled only when `busy`=0.
- `a1..a4`, `b1..b4` in W each: vector pair 0.
- `c1..c4`, `d1..d4` in W each: vector pair 1.
- `e1..e4`, `f1..f4` in W each: vector pair 2.
- `busy` out 1: high while a computation is in progress.
- `done` out 1: one-cycle pulse; the result outputs updated on this cycle.
- `g1..g4`, `h1..h4`, `i1..i4` out W each: registered results for pairs 0, 1 and 2.

## Operation
- Element rule: result_k = (x_k × y_k) reduced to W bits. The reduction is truncation to the low W bits by default; see Configuration. Products are unsigned.
- FSM states:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- IDLE→RUN on `start`=1. All 24 operand inputs are captured into an internal operand register on that edge. The index counter `idx` is set to 0.
- RUN: each cycle the shared multiplier computes element `idx` and writes it into a shadow result register. Ordering:
  - `idx` 0–3: a1·b1 … a4·b4.
  - `idx` 4–7: c·d.
  - `idx` 8–11: e·f.
- RUN→DONE on the edge where `idx`=11. On that same edge, all twelve output registers load from the shadow register, with the `idx`=11 product taken directly from the multiplier.
- DONE→RUN if `start`=1 (new operands captured, back-to-back). DONE→IDLE otherwise.
- Outputs hold their previous values throughout RUN. A partial result is never visible.
- `start` while in RUN is ignored, with no queuing. Input changes during RUN have no effect because operands are captured.
- Reset (any state, including mid-RUN): go to IDLE and set `idx`=0. All outputs, the shadow register and the operand register go to 0. `busy`=0 and `done`=0. The in-flight computation is discarded and no `done` is issued for it.

## Timing
- Reset values: `busy`=0, `done`=0, all g/h/i = 0.
- `start` sampled high at edge E0 (IDLE or DONE):
  - `busy`=1 from E0 to E12.
  - `done`=1 and new outputs visible from E12 to E13.
- Latency: 12 cycles from the accepting edge to output update. Maximum throughput is one result set per 13 cycles.
- `start` held high continuously gives `done` every 13 cycles.
- `start` asserted together with `rst`: reset wins and `start` is ignored.
- The multiplier is combinational within one cycle. No multicycle path is permitted.

## Configuration
- `SERIALISERING_SAT_EN` defined:
  - Each product saturates to 2^W−1 when the full 2W-bit product exceeds it.
  - Example: 20×20=400 → 255.
- `SERIALISERING_SAT_EN` undefined:
  - Plain truncation to the low W bits, bit-identical to the parallel stage.
  - Example: 20×20=400 → 144.
- Only the reduction logic inside the element multiplier changes. The FSM and timing are identical in both builds.

## Structure
- Shared package `serialisering_pkg` contains:
  - Constants: `LANES`=3, `ELEMS`=4, `STEPS`=LANES×ELEMS=12, `IDX_W`=4.
  - Enum `state_t` {IDLE, RUN, DONE}.
- One sub-module, `elementprodukt`:
  - Combinational W×W multiply plus reduction (truncate, or saturate under the macro).
  - Instantiated once. It is the shared resource.
- Top-level `serialisering` holds the FSM, `idx` counter, operand mux, operand/shadow registers and output registers.

## Test plan
- Basic: A=(1,2,3,4), B=(5,6,7,8), C=D=(2,2,2,2), E=(0,1,0,1), F=(9,9,9,9), `start` 1 cycle → `done` exactly 12 cycles after acceptance. Expected results:
  - G=(5,12,21,32)
  - H=(4,4,4,4)
  - I=(0,9,0,9)
- Overflow: a1=b1=20, a2=b2=255, others 1 → without the macro, g1=144 and g2=1. With `SERIALISERING_SAT_EN`, g1=255 and g2=255.
- Operand capture/ignored start: change all inputs and pulse `start` during RUN → the results reflect the originally captured operands, and there is exactly one `done`.
- Back-to-back: `start` held high for 40 cycles → `done` at acceptance+12, +25 and +38, each with correct results. `busy`=0 only in the DONE cycles.
- Reset mid-operation: `rst` asserted at `idx`=6 → next cycle all outputs are 0, `busy`=0, no `done`. A following start with the basic vectors yields the basic results.
- Hold: after `done`, inputs changed with no `start` → outputs remain unchanged for 20 cycles.

Source files
------------

// File: rtl/serialisering_pkg.sv
// Shared constants and FSM state type for the serialised vector-multiply stage.
// Build option: SERIALISERING_SAT_EN selects saturating element products.
package serialisering_pkg;

    localparam int LANES = 3;
    localparam int ELEMS = 4;
    localparam int STEPS = LANES * ELEMS;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serialisering_elementprodukt.sv
// Shared combinational W x W unsigned multiplier with reduction back to W bits.
// SERIALISERING_SAT_EN defined: saturate to 2^W-1; otherwise keep the low W bits.
module elementprodukt #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    logic [2*W-1:0] full;

    assign full = {{W{1'b0}}, x} * {{W{1'b0}}, y};

`ifdef SERIALISERING_SAT_EN
    assign p = (|full[2*W-1:W]) ? {W{1'b1}} : full[W-1:0];
`else
    assign p = full[W-1:0];
`endif

endmodule

// File: rtl/serialisering.sv
// Three-lane element-wise vector multiply through one shared multiplier, 12 cycles per set.
// SERIALISERING_SAT_EN (in elementprodukt) switches truncation to saturation.
module serialisering
    import serialisering_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a1, a2, a3, a4,
    input  logic [W-1:0] b1, b2, b3, b4,
    input  logic [W-1:0] c1, c2, c3, c4,
    input  logic [W-1:0] d1, d2, d3, d4,
    input  logic [W-1:0] e1, e2, e3, e4,
    input  logic [W-1:0] f1, f2, f3, f4,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] g1, g2, g3, g4,
    output logic [W-1:0] h1, h2, h3, h4,
    output logic [W-1:0] i1, i2, i3, i4
);

    state_t         state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic           busy_reg;
    logic           done_reg;

    logic [W-1:0] x_in     [STEPS];
    logic [W-1:0] y_in     [STEPS];
    logic [W-1:0] x_reg    [STEPS];
    logic [W-1:0] y_reg    [STEPS];
    logic [W-1:0] shadow_reg [STEPS];
    logic [W-1:0] out_reg  [STEPS];

    logic [W-1:0] mul_x;
    logic [W-1:0] mul_y;
    logic [W-1:0] prod;

    // Element order follows idx: pair 0 first, then pair 1, then pair 2.
    assign x_in = '{a1, a2, a3, a4, c1, c2, c3, c4, e1, e2, e3, e4};
    assign y_in = '{b1, b2, b3, b4, d1, d2, d3, d4, f1, f2, f3, f4};

    assign mul_x = x_reg[idx_reg];
    assign mul_y = y_reg[idx_reg];

    elementprodukt #(.W(W)) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int k = 0; k < STEPS; k++) begin
                x_reg[k]      <= '0;
                y_reg[k]      <= '0;
                shadow_reg[k] <= '0;
                out_reg[k]    <= '0;
            end
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        for (int k = 0; k < STEPS; k++) begin
                            x_reg[k] <= x_in[k];
                            y_reg[k] <= y_in[k];
                        end
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    shadow_reg[idx_reg] <= prod;
                    if (idx_reg == IDX_W'(STEPS - 1)) begin
                        // Last product bypasses the shadow so all results appear on one edge.
                        for (int k = 0; k < STEPS; k++) begin
                            out_reg[k] <= (k == STEPS - 1) ? prod : shadow_reg[k];
                        end
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    assign g1 = out_reg[0];
    assign g2 = out_reg[1];
    assign g3 = out_reg[2];
    assign g4 = out_reg[3];
    assign h1 = out_reg[4];
    assign h2 = out_reg[5];
    assign h3 = out_reg[6];
    assign h4 = out_reg[7];
    assign i1 = out_reg[8];
    assign i2 = out_reg[9];
    assign i3 = out_reg[10];
    assign i4 = out_reg[11];

endmodule

// File: tb/tb_serialisering.sv
// Scoreboard bench for serialisering: stimulus pushes expected result sets, a monitor checks each done.
// Expected overflow results follow SERIALISERING_SAT_EN.
module tb_serialisering;

    typedef logic [7:0] vec_t [12];
    typedef struct {
        int   cyc;
        vec_t r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    vec_t x;
    vec_t y;
    vec_t got;
    logic busy, done;
    logic [7:0] g1, g2, g3, g4, h1, h2, h3, h4, i1, i2, i3, i4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    vec_t basic_r = '{8'd5, 8'd12, 8'd21, 8'd32, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0, 8'd9, 8'd0, 8'd9};
`ifdef SERIALISERING_SAT_EN
    vec_t ov_r = '{8'd255, 8'd255, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`else
    vec_t ov_r = '{8'd144, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`endif
    vec_t zero_r = '{default: 8'd0};

    serialisering #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a1(x[0]), .a2(x[1]), .a3(x[2]), .a4(x[3]),
        .b1(y[0]), .b2(y[1]), .b3(y[2]), .b4(y[3]),
        .c1(x[4]), .c2(x[5]), .c3(x[6]), .c4(x[7]),
        .d1(y[4]), .d2(y[5]), .d3(y[6]), .d4(y[7]),
        .e1(x[8]), .e2(x[9]), .e3(x[10]), .e4(x[11]),
        .f1(y[8]), .f2(y[9]), .f3(y[10]), .f4(y[11]),
        .busy(busy), .done(done),
        .g1(g1), .g2(g2), .g3(g3), .g4(g4),
        .h1(h1), .h2(h2), .h3(h3), .h4(h4),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        got[0] = g1;  got[1] = g2;  got[2] = g3;  got[3] = g4;
        got[4] = h1;  got[5] = h2;  got[6] = h3;  got[7] = h4;
        got[8] = i1;  got[9] = i2;  got[10] = i3; got[11] = i4;
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d (no result set outstanding)", cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d want=%0d", cyc, mon_e.cyc);
                end
                for (int k = 0; k < 12; k++) begin
                    checks++;
                    if (got[k] !== mon_e.r[k]) begin
                        errors++;
                        $display("FAIL result[%0d] got=%0d want=%0d", k, got[k], mon_e.r[k]);
                    end
                end
                $display("done at cyc %0d g=%0d,%0d,%0d,%0d h=%0d,%0d,%0d,%0d i=%0d,%0d,%0d,%0d",
                         cyc, g1, g2, g3, g4, h1, h2, h3, h4, i1, i2, i3, i4);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic chk_outs(input string name, input vec_t want);
        checks++;
        for (int k = 0; k < 12; k++) begin
            if (got[k] !== want[k]) begin
                errors++;
                $display("FAIL %s elem=%0d got=%0d want=%0d", name, k, got[k], want[k]);
                break;
            end
        end
    endtask

    task automatic set_basic();
        x = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd1, 8'd0, 8'd1};
        y = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd2, 8'd2, 8'd2, 8'd2, 8'd9, 8'd9, 8'd9, 8'd9};
    endtask

    task automatic push_exp(input int c, input vec_t r);
        exp_t e;
        e.cyc = c;
        e.r   = r;
        q.push_back(e);
    endtask

    // Raise start for one edge; done is due 13 counter steps after the drive point.
    task automatic pulse_start(input vec_t r);
        @(posedge clk); #1;
        start = 1'b1;
        push_exp(cyc + 13, r);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 60 && q.size() != 0; n++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout outstanding=%0d want=0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k0;
        set_basic();
        start = 1'b1;  // must be ignored while reset is held
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk_outs("reset_outputs", zero_r);
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;

        // Basic vectors
        pulse_start(basic_r);
        wait_drain("basic");

        // Overflow behaviour of element 1 and 2
        x = '{default: 8'd1};
        y = '{default: 8'd1};
        x[0] = 8'd20;  y[0] = 8'd20;
        x[1] = 8'd255; y[1] = 8'd255;
        pulse_start(ov_r);
        wait_drain("overflow");

        // Operands captured; start during RUN ignored
        set_basic();
        pulse_start(basic_r);
        repeat (3) @(posedge clk);
        #1;
        x = '{default: 8'd7};
        y = '{default: 8'd3};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain("capture");
        repeat (15) @(negedge clk);

        // Back-to-back with start held over edges E0..E38
        set_basic();
        @(posedge clk); #1;
        start = 1'b1;
        k0 = cyc;
        push_exp(k0 + 13, basic_r);
        push_exp(k0 + 26, basic_r);
        push_exp(k0 + 39, basic_r);
        @(negedge clk);
        for (int t = 0; t <= 38; t++) begin
            @(negedge clk);
            chk($sformatf("b2b_busy_t%0d", t), int'(busy),
                (t == 12 || t == 25 || t == 38) ? 0 : 1);
            if (t == 38) start = 1'b0;
        end
        wait_drain("b2b");
        repeat (3) @(negedge clk);

        // Reset at idx 6
        set_basic();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk_outs("midrst_outputs", zero_r);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        pulse_start(basic_r);
        wait_drain("after_reset");

        // Hold: inputs change without start
        x = '{default: 8'd9};
        y = '{default: 8'd11};
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            chk_outs($sformatf("hold_t%0d", t), basic_r);
            chk($sformatf("hold_busy_t%0d", t), int'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
